// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// One cache line equals one memory block, so every memory transaction moves a full line.
// Block word 0 sits at the MSBs of mem_rblock / mem_wblock.
// Optional feature macro: DCACHE_STATS_EN adds hit_count / miss_count outputs.
module dcache_ctrl #(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 16,
    parameter int LINES      = 8,
    parameter int MEM_WAIT   = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cpu_req,
    input  logic                             cpu_we,
    input  logic [WORD_SIZE-1:0]             cpu_addr,
    input  logic [WORD_SIZE-1:0]             cpu_wdata,
    output logic [WORD_SIZE-1:0]             cpu_rdata,
    output logic                             cpu_ready,
    output logic [WORD_SIZE-1:0]             mem_ptr,
    output logic [BLOCK_SIZE*WORD_SIZE-1:0]  mem_wblock,
    input  logic [BLOCK_SIZE*WORD_SIZE-1:0]  mem_rblock,
    output logic                             mem_we
`ifdef DCACHE_STATS_EN
    ,
    output logic [WORD_SIZE-1:0]             hit_count,
    output logic [WORD_SIZE-1:0]             miss_count
`endif
);

    localparam int OFF  = $clog2(BLOCK_SIZE);
    localparam int IDX  = $clog2(LINES);
    localparam int TAG  = WORD_SIZE - OFF - IDX;
    localparam int LW   = BLOCK_SIZE * WORD_SIZE;
    localparam int LSBW = $clog2(LW);
    localparam int WW   = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t               state_q, state_d;
    logic                 req_we_q, req_we_d;
    logic [WORD_SIZE-1:0] req_addr_q, req_addr_d;
    logic [WORD_SIZE-1:0] req_wdata_q, req_wdata_d;
    logic [WORD_SIZE-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                 cpu_ready_q, cpu_ready_d;
    logic                 mem_we_q, mem_we_d;
    logic [WORD_SIZE-1:0] mem_ptr_q, mem_ptr_d;
    logic [LW-1:0]        mem_wblock_q, mem_wblock_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [LINES-1:0]     dirty_q, dirty_d;

    // Tag and data arrays carry no reset; valid gates their use.
    logic [TAG-1:0]       tag_q  [LINES];
    logic [LW-1:0]        data_q [LINES];

    logic [TAG-1:0]       req_tag;
    logic [IDX-1:0]       req_idx;
    logic [OFF-1:0]       req_off;
    logic [LW-1:0]        cur_line;
    logic [TAG-1:0]       cur_tag;
    logic                 hit;
    logic [LSBW-1:0]      word_lsb;
    logic                 line_we;
    logic [LW-1:0]        line_wdata;
    logic                 tag_we;

    assign req_tag  = req_addr_q[WORD_SIZE-1 -: TAG];
    assign req_idx  = req_addr_q[OFF+IDX-1:OFF];
    assign req_off  = req_addr_q[OFF-1:0];
    assign cur_line = data_q[req_idx];
    assign cur_tag  = tag_q[req_idx];
    assign hit      = valid_q[req_idx] && (cur_tag == req_tag);
    // Word k lives at bit (BLOCK_SIZE-1-k)*WORD_SIZE; ~offset == BLOCK_SIZE-1-offset.
    assign word_lsb = LSBW'(~req_off) * LSBW'(WORD_SIZE);

    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ready  = cpu_ready_q;
    assign mem_ptr    = mem_ptr_q;
    assign mem_wblock = mem_wblock_q;
    assign mem_we     = mem_we_q;

    // Next-state and registered-output logic for the controller FSM.
    always_comb begin
        state_d      = state_q;
        req_we_d     = req_we_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_ready_d  = 1'b0;
        mem_we_d     = 1'b0;
        mem_ptr_d    = mem_ptr_q;
        mem_wblock_d = mem_wblock_q;
        wait_d       = wait_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        line_we      = 1'b0;
        line_wdata   = cur_line;
        tag_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    req_we_d    = cpu_we;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    state_d     = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    if (req_we_q) begin
                        line_wdata[word_lsb +: WORD_SIZE] = req_wdata_q;
                        line_we          = 1'b1;
                        dirty_d[req_idx] = 1'b1;
                    end else begin
                        cpu_rdata_d = cur_line[word_lsb +: WORD_SIZE];
                    end
                    cpu_ready_d = 1'b1;
                    state_d     = IDLE;
                end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                    // Victim goes out in the single WRITEBACK cycle.
                    mem_we_d     = 1'b1;
                    mem_ptr_d    = {cur_tag, req_idx, {OFF{1'b0}}};
                    mem_wblock_d = cur_line;
                    state_d      = WRITEBACK;
                end else begin
                    mem_ptr_d = {req_tag, req_idx, {OFF{1'b0}}};
                    wait_d    = '0;
                    state_d   = ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_ptr_d = {req_tag, req_idx, {OFF{1'b0}}};
                wait_d    = '0;
                state_d   = ALLOCATE;
            end
            ALLOCATE: begin
                if (wait_q == WW'(MEM_WAIT - 1)) begin
                    line_we          = 1'b1;
                    line_wdata       = mem_rblock;
                    tag_we           = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    state_d          = COMPARE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered outputs, asynchronously reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            cpu_ready_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_ptr_q    <= '0;
            mem_wblock_q <= '0;
            wait_q       <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_we_q     <= req_we_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_ready_q  <= cpu_ready_d;
            mem_we_q     <= mem_we_d;
            mem_ptr_q    <= mem_ptr_d;
            mem_wblock_q <= mem_wblock_d;
            wait_q       <= wait_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
        end
    end

    // Line storage: refill or store-merge into the indexed line.
    always_ff @(posedge clk) begin
        if (line_we) data_q[req_idx] <= line_wdata;
        if (tag_we)  tag_q[req_idx]  <= req_tag;
    end

`ifdef DCACHE_STATS_EN
    logic                 first_q, first_d;
    logic [WORD_SIZE-1:0] hit_count_q, hit_count_d;
    logic [WORD_SIZE-1:0] miss_count_q, miss_count_d;

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // Count only the first COMPARE of each request; the post-refill one is skipped.
    always_comb begin
        first_d      = first_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == IDLE && cpu_req) begin
            first_d = 1'b1;
        end else if (state_q == COMPARE) begin
            first_d = 1'b0;
            if (first_q) begin
                if (hit) hit_count_d  = hit_count_q + 1'b1;
                else     miss_count_d = miss_count_q + 1'b1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q      <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            first_q      <= first_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: block memory model plus a CPU-view reference model.
// The reference keeps the word values a load must return, what memory should hold,
// and which block each line caches, and predicts latency / writebacks from those.
module tb_dcache_ctrl;
    localparam int W    = 32;
    localparam int B    = 16;
    localparam int L    = 8;
    localparam int MW   = 2;
    localparam int MEMN = 1024;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cpu_req = 1'b0;
    logic             cpu_we = 1'b0;
    logic [W-1:0]     cpu_addr = '0;
    logic [W-1:0]     cpu_wdata = '0;
    logic [W-1:0]     cpu_rdata;
    logic             cpu_ready;
    logic [W-1:0]     mem_ptr;
    logic [B*W-1:0]   mem_wblock;
    logic [B*W-1:0]   mem_rblock;
    logic             mem_we;
`ifdef DCACHE_STATS_EN
    logic [W-1:0]     hit_count;
    logic [W-1:0]     miss_count;
`endif

    dcache_ctrl #(.WORD_SIZE(W), .BLOCK_SIZE(B), .LINES(L), .MEM_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .mem_ptr(mem_ptr), .mem_wblock(mem_wblock),
        .mem_rblock(mem_rblock), .mem_we(mem_we)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT.
    logic [W-1:0] mem [MEMN];
    int           rbase;
    always_comb begin
        mem_rblock = '0;
        rbase = int'({mem_ptr[9:4], 4'b0000});
        for (int k = 0; k < B; k++) mem_rblock[(B-k)*W-1 -: W] = mem[rbase + k];
    end
    always @(posedge clk) begin
        if (mem_we)
            for (int k = 0; k < B; k++) mem[int'({mem_ptr[9:4], 4'b0000}) + k] <= mem_wblock[(B-k)*W-1 -: W];
    end

    // Reference model.
    logic [W-1:0] gold [MEMN];   // value a load must return
    logic [W-1:0] gmem [MEMN];   // value memory must hold
    bit           m_valid [L];
    bit           m_dirty [L];
    int           m_tag [L];
    logic [W-1:0] m_ptr;
    int           m_hits, m_miss;

    int nvec = 0;
    int nerr = 0;

    task automatic model_reset();
        for (int i = 0; i < L; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        for (int a = 0; a < MEMN; a++) gold[a] = gmem[a];
        m_ptr = '0; m_hits = 0; m_miss = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            nvec++;
            if (cpu_ready !== 1'b0 || mem_we !== 1'b0) begin
                nerr++;
                $display("FAIL idle_quiet: ready=%b we=%b want 0 0", cpu_ready, mem_we);
            end
        end
    endtask

    // Issue one request and check it; called at #1 into an IDLE cycle.
    task automatic do_req(input bit we, input int addr, input logic [W-1:0] wd);
        int idx, tag, lat, n, wbn, wb_ptr, wbp;
        bit hit, dirtyv, bad;
        logic [B*W-1:0] wblk;
        logic [W-1:0] exp_ptr;
        idx = (addr >> 4) % L; tag = addr >> 7;
        hit = m_valid[idx] && m_tag[idx] == tag;
        dirtyv = !hit && m_valid[idx] && m_dirty[idx];
        lat = hit ? 2 : (dirtyv ? 4 + MW : 3 + MW);
        wb_ptr = (m_tag[idx] << 7) | (idx << 4);
        exp_ptr = hit ? m_ptr : W'(addr & ~15);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = W'(addr); cpu_wdata = wd;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = $urandom_range(0, 1); cpu_addr = $urandom; cpu_wdata = $urandom;
        n = 1; wbn = 0; wbp = 0; wblk = '0;
        forever begin
            if (mem_we === 1'b1) begin wbn++; wbp = int'(mem_ptr); wblk = mem_wblock; end
            if (cpu_ready === 1'b1 || n >= 40) break;
            @(posedge clk); #1; n++;
        end
        nvec++;
        if (cpu_ready !== 1'b1 || n != lat) begin
            nerr++;
            $display("FAIL latency addr=%0h: got %0d cycles (ready=%b) want %0d", addr, n, cpu_ready, lat);
        end
        nvec++;
        if (wbn != (dirtyv ? 1 : 0)) begin
            nerr++;
            $display("FAIL wb_count addr=%0h: got %0d mem_we pulses want %0d", addr, wbn, dirtyv);
        end
        if (dirtyv && wbn == 1) begin
            nvec++;
            if (wbp != wb_ptr) begin
                nerr++;
                $display("FAIL wb_ptr addr=%0h: got %0h want %0h", addr, wbp, wb_ptr);
            end
            bad = 0;
            for (int k = 0; k < B; k++) if (wblk[(B-k)*W-1 -: W] !== gold[wb_ptr + k]) bad = 1;
            nvec++;
            if (bad) begin
                nerr++;
                $display("FAIL wb_data ptr=%0h: word0 got %0h want %0h", wb_ptr, wblk[B*W-1 -: W], gold[wb_ptr]);
            end
        end
        if (!we) begin
            nvec++;
            if (cpu_rdata !== gold[addr]) begin
                nerr++;
                $display("FAIL rdata addr=%0h: got %0h want %0h", addr, cpu_rdata, gold[addr]);
            end
        end
        nvec++;
        if (mem_ptr !== exp_ptr) begin
            nerr++;
            $display("FAIL mem_ptr addr=%0h: got %0h want %0h", addr, mem_ptr, exp_ptr);
        end
        if (dirtyv) for (int k = 0; k < B; k++) gmem[wb_ptr + k] = gold[wb_ptr + k];
        if (!hit) begin
            m_valid[idx] = 1; m_tag[idx] = tag; m_dirty[idx] = 0;
            m_ptr = W'(addr & ~15); m_miss++;
        end else m_hits++;
        if (we) begin gold[addr] = wd; m_dirty[idx] = 1; end
    endtask

    task automatic check_stats(input string name);
`ifdef DCACHE_STATS_EN
        nvec++;
        if (hit_count !== W'(m_hits) || miss_count !== W'(m_miss)) begin
            nerr++;
            $display("FAIL %s: got hits=%0d misses=%0d want %0d %0d", name, hit_count, miss_count, m_hits, m_miss);
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h25;
        #3;
        nvec++;
        if (cpu_ready !== 1'b0 || mem_we !== 1'b0 || cpu_rdata !== '0 || mem_ptr !== '0) begin
            nerr++;
            $display("FAIL reset_values: ready=%b we=%b rdata=%0h ptr=%0h want 0 0 0 0", cpu_ready, mem_we, cpu_rdata, mem_ptr);
        end
        @(posedge clk); #1; cpu_req = 1'b0; rst_n = 1'b1;
        model_reset();
        idle(2);
        check_stats("stats_reset");
    endtask

    task automatic test_directed();
        do_req(0, 'h25, '0);          // clean miss
        do_req(0, 'h2F, '0);          // hit, back-to-back
        idle(1);
        do_req(1, 'h21, 32'hDEADBEEF); // store hit
        do_req(0, 'hA1, '0);          // dirty miss -> writeback
        check_stats("stats_after_1_4");
        do_req(0, 'h21, '0);          // clean victim, data from memory
        idle(1);
    endtask

    // Reset in the middle of a miss: in ALLOCATE (clean) or WRITEBACK (dirty).
    task automatic test_reset_midop(input bit dirty);
        int ready_seen;
        if (dirty) begin do_req(1, 'h305, 32'h12345678); idle(1); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = dirty ? 32'h105 : 32'h125;
        @(posedge clk); #1; cpu_req = 1'b0;
        @(posedge clk); #1;
        if (dirty) begin
            nvec++;
            if (mem_we !== 1'b1) begin
                nerr++;
                $display("FAIL midop_wb_pulse: got mem_we=%b want 1", mem_we);
            end
        end else begin
            @(posedge clk); #1;
            nvec++;
            if (mem_ptr !== 32'h120) begin
                nerr++;
                $display("FAIL midop_alloc_ptr: got %0h want 120", mem_ptr);
            end
        end
        rst_n = 1'b0; #1;
        nvec++;
        if (cpu_ready !== 1'b0 || mem_we !== 1'b0) begin
            nerr++;
            $display("FAIL midop_async: ready=%b we=%b want 0 0", cpu_ready, mem_we);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        model_reset();
        ready_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (cpu_ready === 1'b1 || mem_we === 1'b1) ready_seen++;
        end
        nvec++;
        if (ready_seen != 0) begin
            nerr++;
            $display("FAIL midop_dropped: got %0d active cycles want 0", ready_seen);
        end
        if (dirty) do_req(0, 'h305, '0);  // store was lost with the reset
        else       do_req(0, 'h2F, '0);   // cache emptied -> miss
        idle(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            do_req(bit'($urandom_range(0, 1)), int'($urandom_range(0, MEMN - 1)), $urandom);
            idle(int'($urandom_range(0, 2)));
        end
        check_stats("stats_random");
    endtask

    initial begin
        for (int a = 0; a < MEMN; a++) begin mem[a] = W'(a); gmem[a] = W'(a); end
        test_reset();
        test_directed();
        test_reset_midop(0);
        test_reset_midop(1);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
